// File: rtl/aes_round_sequencer.sv
// AES-128 round control: key expansion, then ARK/SB/SR/MC steps in cipher order on a 128-bit state.
// Two cycles per step with a 1-cycle unit. start is ignored while busy; a stalled unit trips the watchdog.
module aes_round_sequencer #(
  parameter int NUM_ROUNDS = 10,
  parameter int TIMEOUT    = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] data_in,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic [127:0] data_out,
  output logic [3:0]   round_num,
  output logic [127:0] stage_in,
  input  logic [127:0] stage_out,
  output logic         keyexp_enable,
  input  logic         keyexp_finished,
  output logic         sbytes_enable,
  input  logic         sbytes_finished,
  output logic         srows_enable,
  input  logic         srows_finished,
  output logic         mcol_enable,
  input  logic         mcol_finished,
  output logic         around_enable,
  input  logic         around_finished
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, KEYEXP, ARK, SB, SR, MC, DONE, ERROR
  } state_t;

  state_t          state, state_nxt;
  logic            first;
  logic [WD_W-1:0] wd;
  logic            fin_sel;
  logic            step;
  logic            accept;
  logic            timeout;
  logic            last_round;

  always_comb begin
    fin_sel = 1'b0;
    case (state)
      KEYEXP:  fin_sel = keyexp_finished;
      ARK:     fin_sel = around_finished;
      SB:      fin_sel = sbytes_finished;
      SR:      fin_sel = srows_finished;
      MC:      fin_sel = mcol_finished;
      default: fin_sel = 1'b0;
    endcase
  end

  assign step       = (state == KEYEXP) || (state == ARK) || (state == SB) ||
                      (state == SR) || (state == MC);
  // finished in the enable cycle is stale from the previous operation
  assign accept     = step && !first && fin_sel;
  assign timeout    = step && !accept && (wd == WD_W'(TIMEOUT - 1));
  assign last_round = (round_num == 4'(NUM_ROUNDS));
  assign stage_in   = data_out;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, ERROR: if (start) state_nxt = KEYEXP;
      KEYEXP:      if (accept) state_nxt = ARK;
      ARK:         if (accept) state_nxt = last_round ? DONE : SB;
      SB:          if (accept) state_nxt = SR;
      SR:          if (accept) state_nxt = last_round ? ARK : MC;
      MC:          if (accept) state_nxt = ARK;
      DONE:        state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase
    if (timeout) state_nxt = ERROR;
  end

  always_comb begin
    busy          = 1'b1;
    done          = 1'b0;
    error         = 1'b0;
    keyexp_enable = 1'b0;
    around_enable = 1'b0;
    sbytes_enable = 1'b0;
    srows_enable  = 1'b0;
    mcol_enable   = 1'b0;
    case (state)
      IDLE:    busy = 1'b0;
      ERROR:   begin busy = 1'b0; error = 1'b1; end
      DONE:    done = 1'b1;
      KEYEXP:  keyexp_enable = first;
      ARK:     around_enable = first;
      SB:      sbytes_enable = first;
      SR:      srows_enable  = first;
      MC:      mcol_enable   = first;
      default: busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out  <= '0;
      round_num <= '0;
      wd        <= '0;
      first     <= 1'b0;
    end else begin
      first <= (state_nxt != state);
      if (state_nxt != state) wd <= '0;
      else if (step)          wd <= wd + WD_W'(1);
      if (((state == IDLE) || (state == ERROR)) && start) begin
        data_out  <= data_in;
        round_num <= '0;
      end else if (accept && (state != KEYEXP)) begin
        data_out <= stage_out;
      end
      // round advances only when leaving add-round-key, so it is stable across a round
      if ((state == ARK) && accept && !last_round) round_num <= round_num + 4'd1;
    end
  end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed bench: 1..20 cycle responders returning stage_in+1, enable log and expected FIPS-197 order.
module tb_aes_round_sequencer;
  localparam int NR  = 10;
  localparam int TMO = 255;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [127:0] data_in, data_out, stage_in, stage_out;
  logic         busy, done, error;
  logic [3:0]   round_num;
  logic         keyexp_enable, around_enable, sbytes_enable, srows_enable, mcol_enable;
  logic [4:0]   fin;

  always #5 clk = ~clk;

  aes_round_sequencer #(.NUM_ROUNDS(NR), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in),
    .busy(busy), .done(done), .error(error), .data_out(data_out),
    .round_num(round_num), .stage_in(stage_in), .stage_out(stage_out),
    .keyexp_enable(keyexp_enable), .keyexp_finished(fin[0]),
    .around_enable(around_enable), .around_finished(fin[1]),
    .sbytes_enable(sbytes_enable), .sbytes_finished(fin[2]),
    .srows_enable(srows_enable),   .srows_finished(fin[3]),
    .mcol_enable(mcol_enable),     .mcol_finished(fin[4])
  );

  int checks = 0;
  int fails  = 0;

  // unit ids: 0 keyexp, 1 around, 2 sbytes, 3 srows, 4 mcol
  int cyc = 0;
  int log_len = 0;
  int log_unit[1024];
  int log_round[1024];
  int en_cnt[5] = '{default: 0};
  int last_en_cyc[5] = '{default: 0};
  int done_cnt = 0, done_cyc = 0, err_cnt = 0, err_cyc = 0, multi_en = 0;
  bit err_prev = 1'b0;
  bit pending = 1'b0;
  int cnt = 0, active = 0;
  int lat_max = 1;
  bit spur = 1'b0;
  int hang = -1;

  always @(posedge clk) cyc <= cyc + 1;

  // responder and monitor: everything changes on the falling edge
  always @(negedge clk) begin
    logic [4:0] en;
    int n;
    en = {mcol_enable, srows_enable, sbytes_enable, around_enable, keyexp_enable};
    fin = '0;
    stage_out = {4{32'hDEADBEEF}};
    if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
    if (error === 1'b1 && !err_prev) begin err_cnt++; err_cyc = cyc; end
    err_prev = (error === 1'b1);
    if (en !== 5'b0 && !$isunknown(en)) begin
      n = 0;
      for (int i = 0; i < 5; i++)
        if (en[i]) begin n++; active = i; en_cnt[i]++; last_en_cyc[i] = cyc; end
      if (n > 1) multi_en++;
      if (log_len < 1024) begin log_unit[log_len] = active; log_round[log_len] = int'(round_num); end
      log_len++;
      pending = 1'b1;
      cnt = int'($urandom_range(lat_max - 1, 0));
      if (spur) fin = 5'b11111;
    end else if (pending && busy === 1'b1) begin
      if (cnt == 0 && active != hang) begin
        fin[active] = 1'b1;
        stage_out = stage_in + 128'd1;
        pending = 1'b0;
      end else begin
        if (cnt > 0) cnt--;
        if (spur) fin = 5'($urandom) & ~(5'b1 << active);
      end
    end
  end

  function automatic int exp_unit(input int k);
    if (k == 0) return 0;
    if (k == 1 || k == 40) return 1;
    if (k == 38) return 2;
    if (k == 39) return 3;
    case ((k - 2) % 4)
      0:       return 2;
      1:       return 3;
      2:       return 4;
      default: return 1;
    endcase
  endfunction

  function automatic int exp_round(input int k);
    return (k < 2) ? 0 : (k - 2) / 4 + 1;
  endfunction

  function automatic int order_errs(input int base);
    int e = 0;
    for (int k = 0; k < 41; k++)
      if (log_unit[base + k] != exp_unit(k) || log_round[base + k] != exp_round(k)) e++;
    return e;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_start(input logic [127:0] d, output int t0);
    tick();
    start = 1'b1; data_in = d; t0 = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, output bit to);
    int k = 0;
    while (done_cnt < target && k < budget) begin tick(); k++; end
    to = (done_cnt < target);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; data_in = '0;
    repeat (3) tick();
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (error !== 1'b0) begin fails++; $display("FAIL reset_error: got %b want 0", error); end
    checks++; if (round_num !== 4'd0) begin fails++; $display("FAIL reset_round: got %0d want 0", round_num); end
    checks++; if (data_out !== 128'd0) begin fails++; $display("FAIL reset_data: got %h want 0", data_out); end
    checks++; if ({keyexp_enable, around_enable, sbytes_enable, srows_enable, mcol_enable} !== 5'b0) begin
      fails++; $display("FAIL reset_enables: got %b want 00000",
        {keyexp_enable, around_enable, sbytes_enable, srows_enable, mcol_enable}); end
    rst = 1'b0;
    repeat (2) tick();
    checks++; if (busy !== 1'b0 || stage_in !== 128'd0) begin
      fails++; $display("FAIL idle_hold: busy %b stage_in %h want 0/0", busy, stage_in); end
  endtask

  task automatic test_nominal();
    int t0, b_done;
    int b_cnt[5];
    int exp_cnt[5] = '{1, 11, 10, 10, 9};
    bit to;
    lat_max = 1; spur = 1'b0; hang = -1;
    b_done = done_cnt; b_cnt = en_cnt;
    do_start(128'd0, t0);
    wait_done(b_done + 1, 300, to);
    checks++; if (to) begin fails++; $display("FAIL nominal_timeout: no done within 300 cycles"); end
    checks++; if (done_cyc - t0 != 83) begin fails++; $display("FAIL nominal_done_cycle: got %0d want 83", done_cyc - t0); end
    checks++; if (data_out !== 128'h28) begin fails++; $display("FAIL nominal_data: got %h want 28", data_out); end
    repeat (5) tick();
    checks++; if (done_cnt - b_done != 1) begin fails++; $display("FAIL nominal_done_pulses: got %0d want 1", done_cnt - b_done); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (en_cnt[i] - b_cnt[i] != exp_cnt[i]) begin
        fails++; $display("FAIL nominal_enable_count[%0d]: got %0d want %0d", i, en_cnt[i] - b_cnt[i], exp_cnt[i]); end
    end
    checks++; if (busy !== 1'b0 || round_num !== 4'd10) begin
      fails++; $display("FAIL nominal_after: busy %b round %0d want 0/10", busy, round_num); end
  endtask

  task automatic test_round_order();
    int t0, b_log, b_done, b_multi;
    bit to;
    logic [127:0] d = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    b_log = log_len; b_done = done_cnt; b_multi = multi_en;
    do_start(d, t0);
    wait_done(b_done + 1, 300, to);
    checks++; if (to) begin fails++; $display("FAIL order_timeout: no done within 300 cycles"); end
    checks++; if (log_len - b_log != 41) begin fails++; $display("FAIL order_len: got %0d want 41", log_len - b_log); end
    checks++; if (order_errs(b_log) != 0) begin fails++; $display("FAIL order_seq: got %0d bad entries want 0", order_errs(b_log)); end
    checks++; if (multi_en != b_multi) begin fails++; $display("FAIL order_multi_enable: got %0d want 0", multi_en - b_multi); end
    checks++; if (data_out !== d + 128'd40) begin fails++; $display("FAIL order_data: got %h want %h", data_out, d + 128'd40); end
  endtask

  task automatic test_variable_latency();
    int t0, b_log, b_done;
    int b_cnt[5];
    int exp_cnt[5] = '{1, 11, 10, 10, 9};
    bit to;
    logic [127:0] d = 128'hCAFE_0000_0000_0000_0000_0000_0000_1000;
    lat_max = 20; spur = 1'b1;
    b_log = log_len; b_done = done_cnt; b_cnt = en_cnt;
    do_start(d, t0);
    wait_done(b_done + 1, 2000, to);
    spur = 1'b0; lat_max = 1;
    checks++; if (to) begin fails++; $display("FAIL varlat_timeout: no done within 2000 cycles"); end
    checks++; if (order_errs(b_log) != 0 || log_len - b_log != 41) begin
      fails++; $display("FAIL varlat_seq: got %0d bad of %0d want 0 of 41", order_errs(b_log), log_len - b_log); end
    checks++; if (data_out !== d + 128'd40) begin fails++; $display("FAIL varlat_data: got %h want %h", data_out, d + 128'd40); end
    checks++; if (error !== 1'b0) begin fails++; $display("FAIL varlat_error: got %b want 0", error); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (en_cnt[i] - b_cnt[i] != exp_cnt[i]) begin
        fails++; $display("FAIL varlat_enable_count[%0d]: got %0d want %0d", i, en_cnt[i] - b_cnt[i], exp_cnt[i]); end
    end
  endtask

  task automatic test_watchdog();
    int t0, b_err, b_log, b_done, k;
    bit to;
    logic [127:0] d  = 128'h1000;
    logic [127:0] d2 = 128'h7777_0000;
    logic [127:0] frozen;
    lat_max = 1; hang = 4;
    b_err = err_cnt;
    do_start(d, t0);
    k = 0;
    while (err_cnt == b_err && k < 700) begin tick(); k++; end
    checks++; if (err_cnt == b_err) begin fails++; $display("FAIL wd_no_error: error not raised within 700 cycles"); end
    checks++; if (err_cyc - last_en_cyc[4] != TMO) begin
      fails++; $display("FAIL wd_delay: got %0d want %0d", err_cyc - last_en_cyc[4], TMO); end
    checks++; if (busy !== 1'b0 || error !== 1'b1) begin fails++; $display("FAIL wd_flags: busy %b error %b want 0/1", busy, error); end
    checks++; if (data_out !== d + 128'd3 || round_num !== 4'd1) begin
      fails++; $display("FAIL wd_state: data %h round %0d want %h/1", data_out, round_num, d + 128'd3); end
    frozen = data_out; b_log = log_len;
    repeat (10) tick();
    checks++; if (data_out !== frozen || log_len != b_log || error !== 1'b1) begin
      fails++; $display("FAIL wd_sticky: data %h enables %0d error %b want frozen/0/1", data_out, log_len - b_log, error); end
    hang = -1; b_done = done_cnt;
    do_start(d2, t0);
    checks++; if (error !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL wd_restart: error %b busy %b want 0/1", error, busy); end
    wait_done(b_done + 1, 300, to);
    checks++; if (to || done_cyc - t0 != 83 || data_out !== d2 + 128'd40) begin
      fails++; $display("FAIL wd_recover: done at %0d data %h want 83/%h", done_cyc - t0, data_out, d2 + 128'd40); end
  endtask

  task automatic test_start_filter();
    int t0, b_done, b_key, d1c, d2c;
    bit to1, to2;
    logic [127:0] d  = 128'h500;
    logic [127:0] d3 = 128'h9_0000;
    lat_max = 1;
    b_done = done_cnt; b_key = en_cnt[0];
    tick();
    start = 1'b1; data_in = d; t0 = cyc;
    wait_done(b_done + 1, 300, to1); d1c = done_cyc;
    wait_done(b_done + 2, 300, to2); d2c = done_cyc;
    start = 1'b0;
    checks++; if (to1 || to2) begin fails++; $display("FAIL held_timeout: dones %0d want 2", done_cnt - b_done); end
    checks++; if (d1c - t0 != 83) begin fails++; $display("FAIL held_first_done: got %0d want 83", d1c - t0); end
    checks++; if (d2c - d1c != 84) begin fails++; $display("FAIL held_second_done: got %0d want 84", d2c - d1c); end
    checks++; if (en_cnt[0] - b_key != 2) begin fails++; $display("FAIL held_keyexp: got %0d want 2", en_cnt[0] - b_key); end
    checks++; if (data_out !== d + 128'd40) begin fails++; $display("FAIL held_data: got %h want %h", data_out, d + 128'd40); end
    b_done = done_cnt; b_key = en_cnt[0];
    do_start(d3, t0);
    repeat (20) tick();
    start = 1'b1; data_in = '1; tick(); start = 1'b0;
    repeat (20) tick();
    start = 1'b1; data_in = 128'h5A5A; tick(); start = 1'b0;
    wait_done(b_done + 1, 300, to1);
    checks++; if (to1 || done_cyc - t0 != 83) begin fails++; $display("FAIL pulse_done_cycle: got %0d want 83", done_cyc - t0); end
    checks++; if (data_out !== d3 + 128'd40) begin fails++; $display("FAIL pulse_data: got %h want %h", data_out, d3 + 128'd40); end
    repeat (10) tick();
    checks++; if (en_cnt[0] - b_key != 1 || done_cnt - b_done != 1) begin
      fails++; $display("FAIL pulse_restart: keyexp %0d done %0d want 1/1", en_cnt[0] - b_key, done_cnt - b_done); end
  endtask

  task automatic test_reset_mid();
    int t0, b_done, k;
    bit to;
    logic [127:0] d  = 128'hABC;
    logic [127:0] d2 = 128'h3_0000;
    lat_max = 1;
    b_done = done_cnt;
    do_start(d, t0);
    k = 0;
    while (!(srows_enable === 1'b1 && round_num == 4'd5) && k < 300) begin tick(); k++; end
    checks++; if (k >= 300) begin fails++; $display("FAIL rstmid_reach: SR round 5 not reached within 300 cycles"); end
    rst = 1'b1;
    tick();
    checks++; if (busy !== 1'b0 || round_num !== 4'd0 || data_out !== 128'd0 || done !== 1'b0 || error !== 1'b0) begin
      fails++; $display("FAIL rstmid_state: busy %b round %0d data %h done %b error %b want 0/0/0/0/0",
        busy, round_num, data_out, done, error); end
    rst = 1'b0;
    repeat (5) tick();
    checks++; if (done_cnt != b_done || busy !== 1'b0) begin
      fails++; $display("FAIL rstmid_quiet: dones %0d busy %b want 0/0", done_cnt - b_done, busy); end
    do_start(d2, t0);
    wait_done(b_done + 1, 300, to);
    checks++; if (to || done_cyc - t0 != 83 || data_out !== d2 + 128'd40) begin
      fails++; $display("FAIL rstmid_recover: done at %0d data %h want 83/%h", done_cyc - t0, data_out, d2 + 128'd40); end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; data_in = '0;
    test_reset();
    test_nominal();
    test_round_order();
    test_variable_latency();
    test_watchdog();
    test_start_filter();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
